readback_frame_buffer: RTL and testbench

//  Upstream stage of the frame-write FSM. Captures ICAP readback words into an on-chip RAM.

---
 rtl/readback_frame_buffer_if.sv | 32 +++
 rtl/readback_frame_buffer.sv | 131 +++++++++++++
 tb/tb_readback_frame_buffer.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/readback_frame_buffer_if.sv
// Bus bundle between the ICAP readback source / frame-write FSM and readback_frame_buffer.
// master drives capture control, data and read address; slave (the buffer) returns status and read data.
interface readback_frame_buffer_if #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 32
);
  logic              cap_start;
  logic [15:0]       cap_num_words;
  logic [WORD_W-1:0] O_R;
  logic              cap_valid;
  logic              mod_en;
  logic [15:0]       mod_word_idx;
  logic [WORD_W-1:0] mod_mask;
  logic [ADDR_W-1:0] read_addr;
  logic [WORD_W-1:0] Modified_Words;
  logic              cap_done;
  logic              cap_busy;
  logic [15:0]       cap_count;
  logic              overflow;

  modport master (
    output cap_start, cap_num_words, O_R, cap_valid,
    output mod_en, mod_word_idx, mod_mask, read_addr,
    input  Modified_Words, cap_done, cap_busy, cap_count, overflow
  );

  modport slave (
    input  cap_start, cap_num_words, O_R, cap_valid,
    input  mod_en, mod_word_idx, mod_mask, read_addr,
    output Modified_Words, cap_done, cap_busy, cap_count, overflow
  );
endinterface

// File: rtl/readback_frame_buffer.sv
// Captures ICAP readback words into RAM (optional XOR edit of one word) and serves them on a
// registered read port. Define RBF_BITSWAP_EN to bit-reverse each byte of O_R before storing.
module readback_frame_buffer #(
  parameter int ADDR_W    = 10,
  parameter int WORD_W    = 32,
  parameter int BASE_ADDR = 104
) (
  input  logic                   clk,
  input  logic                   rst,
  readback_frame_buffer_if.slave bus
);
  localparam int                DEPTH   = 2 ** ADDR_W;
  localparam logic [16:0]       DEPTH_L = 17'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [15:0]       num_l;
  logic [15:0]       idx_l;
  logic              mod_en_l;
  logic [WORD_W-1:0] mask_l;
  logic [15:0]       count;
  logic              done;
  logic              busy;
  logic              ovf;
  logic [WORD_W-1:0] rd_data;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] swapped;
  logic [WORD_W-1:0] wr_data;
  logic              wr_en;

`ifdef RBF_BITSWAP_EN
  // SelectMAP ordering: bit i*8+j of each byte lands on bit i*8+7-j.
  always_comb begin
    swapped = bus.O_R;
    for (int i = 0; i < WORD_W / 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        swapped[i*8+7-j] = bus.O_R[i*8+j];
      end
    end
  end
`else
  assign swapped = bus.O_R;
`endif

  assign wr_en   = (state == CAPTURE) && bus.cap_valid;
  assign wr_data = swapped ^ ((mod_en_l && (count == idx_l)) ? mask_l : '0);

  // NOTE: the RAM is deliberately left out of reset so it maps onto block RAM;
  // captured words survive rst, which the frame-write FSM relies on.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: non-blocking update of mem means a same-cycle read of wr_ptr sees the old word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[bus.read_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      wr_ptr   <= BASE;
      num_l    <= '0;
      idx_l    <= '0;
      mod_en_l <= 1'b0;
      mask_l   <= '0;
      count    <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A zero-length capture enters DONE with done cleared; it rises one cycle later.
          if (state == DONE) done <= 1'b1;
          if (bus.cap_start) begin
            num_l    <= bus.cap_num_words;
            idx_l    <= bus.mod_word_idx;
            mod_en_l <= bus.mod_en;
            mask_l   <= bus.mod_mask;
            wr_ptr   <= BASE;
            count    <= '0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            if (bus.cap_num_words == 16'd0) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              state <= CAPTURE;
              busy  <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (bus.cap_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 16'd1;
            if ({1'b0, count} >= DEPTH_L) ovf <= 1'b1;
            if (count + 16'd1 == num_l) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        // NOTE: the unused encoding recovers to IDLE instead of holding an undefined state.
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Modified_Words = rd_data;
  assign bus.cap_done       = done;
  assign bus.cap_busy       = busy;
  assign bus.cap_count      = count;
  assign bus.overflow       = ovf;
endmodule

// File: tb/tb_readback_frame_buffer.sv
// Self-checking bench for readback_frame_buffer: two instances (base 104 and base 1020) driven
// with randomized captures and compared against an address-indexed reference memory.
module tb_readback_frame_buffer;
  localparam int AW     = 10;
  localparam int WW     = 32;
  localparam int DEPTH  = 1024;
  localparam int BASE_A = 104;
  localparam int BASE_B = 1020;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_a, start_b, cap_valid, mod_en;
  logic [15:0]   num_words, mod_idx;
  logic [WW-1:0] o_r, mod_mask;
  logic [AW-1:0] read_addr;

  always #5 clk = ~clk;

  readback_frame_buffer_if #(.ADDR_W(AW), .WORD_W(WW)) if_a ();
  readback_frame_buffer_if #(.ADDR_W(AW), .WORD_W(WW)) if_b ();

  assign if_a.cap_start = start_a;        assign if_b.cap_start = start_b;
  assign if_a.cap_num_words = num_words;  assign if_b.cap_num_words = num_words;
  assign if_a.O_R = o_r;                  assign if_b.O_R = o_r;
  assign if_a.cap_valid = cap_valid;      assign if_b.cap_valid = cap_valid;
  assign if_a.mod_en = mod_en;            assign if_b.mod_en = mod_en;
  assign if_a.mod_word_idx = mod_idx;     assign if_b.mod_word_idx = mod_idx;
  assign if_a.mod_mask = mod_mask;        assign if_b.mod_mask = mod_mask;
  assign if_a.read_addr = read_addr;      assign if_b.read_addr = read_addr;

  readback_frame_buffer #(.ADDR_W(AW), .WORD_W(WW), .BASE_ADDR(BASE_A)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave)
  );
  readback_frame_buffer #(.ADDR_W(AW), .WORD_W(WW), .BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [WW-1:0] mem_a [DEPTH];
  logic [WW-1:0] mem_b [DEPTH];
  logic [WW-1:0] stim  [2048];

  // Reference rule for a stored word: optional per-byte bit reversal, then XOR mask.
  function automatic logic [WW-1:0] ref_store(input logic [WW-1:0] d, input logic [WW-1:0] m);
    logic [WW-1:0] s = d;
`ifdef RBF_BITSWAP_EN
    for (int b = 0; b < WW; b++) s[(b / 8) * 8 + 7 - (b % 8)] = d[b];
`endif
    return s ^ m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_word(input bit use_b, input int addr, output logic [WW-1:0] d);
    read_addr = AW'(addr);
    step();
    d = use_b ? if_b.Modified_Words : if_a.Modified_Words;
  endtask

  // Runs a full capture of n words from stim[] and records expected RAM contents.
  task automatic run_capture(input bit use_b, input int n, input bit men, input int idx,
                             input logic [WW-1:0] mask, input bit gaps, output bit busy_ok);
    int base = use_b ? BASE_B : BASE_A;
    busy_ok   = 1'b1;
    num_words = 16'(n);
    mod_en    = men;
    mod_idx   = 16'(idx);
    mod_mask  = mask;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          busy_ok &= ((use_b ? if_b.cap_busy : if_a.cap_busy) === 1'b1);
          o_r = $urandom;
          step();
        end
      end
      busy_ok &= ((use_b ? if_b.cap_busy : if_a.cap_busy) === 1'b1);
      cap_valid = 1'b1;
      o_r       = stim[k];
      step();
      cap_valid = 1'b0;
      if (use_b) mem_b[(base + k) % DEPTH] = ref_store(stim[k], (men && k == idx) ? mask : '0);
      else       mem_a[(base + k) % DEPTH] = ref_store(stim[k], (men && k == idx) ? mask : '0);
    end
    o_r = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    for (int u = 0; u < 2; u++) begin
      logic [2:0]    flags = (u == 1) ? {if_b.cap_done, if_b.cap_busy, if_b.overflow}
                                      : {if_a.cap_done, if_a.cap_busy, if_a.overflow};
      logic [15:0]   cnt   = (u == 1) ? if_b.cap_count : if_a.cap_count;
      logic [WW-1:0] mw    = (u == 1) ? if_b.Modified_Words : if_a.Modified_Words;
      tests_run++;
      if (flags !== 3'b000) begin
        tests_failed++;
        $display("FAIL reset_flags dut%0d: done/busy/ovf got %b expected 000", u, flags);
      end
      tests_run++;
      if (cnt !== 16'd0) begin
        tests_failed++;
        $display("FAIL reset_count dut%0d: got %0d expected 0", u, cnt);
      end
      tests_run++;
      if (mw !== '0) begin
        tests_failed++;
        $display("FAIL reset_rdata dut%0d: got %h expected 0", u, mw);
      end
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bit busy_ok;
    logic [WW-1:0] d;
    for (int k = 0; k < 5; k++) stim[k] = WW'(k + 1);
    start_a = 1'b1;
    num_words = 16'd5;
    step();
    start_a = 1'b0;
    tests_run++;
    if (if_a.cap_done !== 1'b0 || if_a.cap_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_start: done/busy got %b%b expected 01", if_a.cap_done, if_a.cap_busy);
    end
    read_addr = AW'(BASE_A);
    step();
    for (int k = 0; k < 5; k++) begin
      cap_valid = 1'b1;
      o_r = stim[k];
      step();
      mem_a[BASE_A + k] = ref_store(stim[k], '0);
    end
    cap_valid = 1'b0;
    busy_ok = (if_a.cap_busy === 1'b0);
    tests_run++;
    if (if_a.cap_done !== 1'b1 || !busy_ok || if_a.cap_count !== 16'd5) begin
      tests_failed++;
      $display("FAIL basic_done: done=%b busy=%b count=%0d expected done=1 busy=0 count=5",
               if_a.cap_done, if_a.cap_busy, if_a.cap_count);
    end
    for (int k = 0; k < 5; k++) begin
      read_word(0, BASE_A + k, d);
      tests_run++;
      if (d !== mem_a[BASE_A + k]) begin
        tests_failed++;
        $display("FAIL basic_mem[%0d]: got %h expected %h", BASE_A + k, d, mem_a[BASE_A + k]);
      end
    end
    // Latency: one cycle after read_addr moves to 106, the word appears; not before.
    read_addr = AW'(BASE_A + 2);
    tests_run++;
    if (if_a.Modified_Words !== mem_a[BASE_A + 4]) begin
      tests_failed++;
      $display("FAIL basic_latency_old: got %h expected %h", if_a.Modified_Words, mem_a[BASE_A + 4]);
    end
    step();
    tests_run++;
    if (if_a.Modified_Words !== ref_store(32'd3, '0)) begin
      tests_failed++;
      $display("FAIL basic_latency_new: got %h expected %h", if_a.Modified_Words, ref_store(32'd3, '0));
    end
  endtask

  task automatic test_mod_edit();
    bit busy_ok;
    logic [WW-1:0] d;
    for (int k = 0; k < 4; k++) stim[k] = 32'hA5A5_A5A5;
    run_capture(0, 4, 1'b1, 2, 32'h0000_0100, 1'b0, busy_ok);
    tests_run++;
    if (!busy_ok) begin
      tests_failed++;
      $display("FAIL mod_busy: got busy low during capture expected high");
    end
    for (int k = 0; k < 4; k++) begin
      read_word(0, BASE_A + k, d);
      tests_run++;
      if (d !== mem_a[BASE_A + k]) begin
        tests_failed++;
        $display("FAIL mod_mem[%0d]: got %h expected %h", BASE_A + k, d, mem_a[BASE_A + k]);
      end
`ifndef RBF_BITSWAP_EN
      tests_run++;
      if (d !== ((k == 2) ? 32'hA5A5_A4A5 : 32'hA5A5_A5A5)) begin
        tests_failed++;
        $display("FAIL mod_literal[%0d]: got %h", BASE_A + k, d);
      end
`endif
    end
  endtask

  task automatic test_random();
    bit busy_ok;
    logic [WW-1:0] d;
    repeat (6) begin
      int n   = $urandom_range(1, 40);
      int idx = $urandom_range(0, n + 3);
      bit men = 1'($urandom);
      for (int k = 0; k < n; k++) stim[k] = $urandom;
      run_capture(0, n, men, idx, $urandom, 1'b1, busy_ok);
      tests_run++;
      if (!busy_ok || if_a.cap_done !== 1'b1 || if_a.cap_count !== 16'(n) || if_a.overflow !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand_status n=%0d: busy_ok=%b done=%b count=%0d ovf=%b expected 1 1 %0d 0",
                 n, busy_ok, if_a.cap_done, if_a.cap_count, if_a.overflow, n);
      end
      for (int k = 0; k < n; k++) begin
        read_word(0, BASE_A + k, d);
        tests_run++;
        if (d !== mem_a[BASE_A + k]) begin
          tests_failed++;
          $display("FAIL rand_mem[%0d]: got %h expected %h", BASE_A + k, d, mem_a[BASE_A + k]);
        end
      end
    end
  endtask

  task automatic test_zero_words();
    logic [WW-1:0] d;
    num_words = 16'd0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    cap_valid = 1'b1;
    o_r = ~mem_a[BASE_A];
    tests_run++;
    if (if_a.cap_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_busy: got %b expected 0", if_a.cap_busy);
    end
    step();
    cap_valid = 1'b0;
    tests_run++;
    if (if_a.cap_done !== 1'b1 || if_a.cap_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL zero_done: done=%b count=%0d expected done=1 count=0", if_a.cap_done, if_a.cap_count);
    end
    read_word(0, BASE_A, d);
    tests_run++;
    if (d !== mem_a[BASE_A]) begin
      tests_failed++;
      $display("FAIL zero_nowrite: got %h expected %h", d, mem_a[BASE_A]);
    end
  endtask

  task automatic test_start_ignored();
    logic [WW-1:0] d;
    for (int k = 0; k < 6; k++) stim[k] = $urandom;
    num_words = 16'd6;
    mod_en = 1'b0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cap_valid = 1'b1;
      o_r = stim[k];
      if (k == 2) begin
        start_a = 1'b1;
        num_words = 16'd1;
      end
      step();
      start_a = 1'b0;
      mem_a[BASE_A + k] = ref_store(stim[k], '0);
      if (k == 2) begin
        tests_run++;
        if (if_a.cap_done !== 1'b0 || if_a.cap_busy !== 1'b1 || if_a.cap_count !== 16'd3) begin
          tests_failed++;
          $display("FAIL ignore_mid: done=%b busy=%b count=%0d expected 0 1 3",
                   if_a.cap_done, if_a.cap_busy, if_a.cap_count);
        end
      end
    end
    cap_valid = 1'b0;
    tests_run++;
    if (if_a.cap_done !== 1'b1 || if_a.cap_count !== 16'd6) begin
      tests_failed++;
      $display("FAIL ignore_end: done=%b count=%0d expected 1 6", if_a.cap_done, if_a.cap_count);
    end
    for (int k = 0; k < 6; k++) begin
      read_word(0, BASE_A + k, d);
      tests_run++;
      if (d !== mem_a[BASE_A + k]) begin
        tests_failed++;
        $display("FAIL ignore_mem[%0d]: got %h expected %h", BASE_A + k, d, mem_a[BASE_A + k]);
      end
    end
  endtask

  task automatic test_read_first();
    logic [WW-1:0] old_word = mem_a[BASE_A];
    num_words = 16'd1;
    mod_en = 1'b0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    read_addr = AW'(BASE_A);
    cap_valid = 1'b1;
    o_r = ~old_word;
    step();
    cap_valid = 1'b0;
    mem_a[BASE_A] = ref_store(~old_word, '0);
    tests_run++;
    if (if_a.Modified_Words !== old_word) begin
      tests_failed++;
      $display("FAIL read_first_old: got %h expected %h", if_a.Modified_Words, old_word);
    end
    step();
    tests_run++;
    if (if_a.Modified_Words !== mem_a[BASE_A]) begin
      tests_failed++;
      $display("FAIL read_first_new: got %h expected %h", if_a.Modified_Words, mem_a[BASE_A]);
    end
  endtask

  task automatic test_wrap();
    bit busy_ok;
    logic [WW-1:0] d;
    int addrs [6] = '{1020, 1021, 1022, 1023, 0, 1};
    for (int k = 0; k < 6; k++) stim[k] = $urandom;
    run_capture(1, 6, 1'b0, 0, '0, 1'b1, busy_ok);
    tests_run++;
    if (!busy_ok || if_b.overflow !== 1'b0 || if_b.cap_count !== 16'd6 || if_b.cap_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap6_status: busy_ok=%b ovf=%b count=%0d done=%b expected 1 0 6 1",
               busy_ok, if_b.overflow, if_b.cap_count, if_b.cap_done);
    end
    for (int k = 0; k < 6; k++) begin
      read_word(1, addrs[k], d);
      tests_run++;
      if (d !== mem_b[addrs[k]]) begin
        tests_failed++;
        $display("FAIL wrap6_mem[%0d]: got %h expected %h", addrs[k], d, mem_b[addrs[k]]);
      end
    end
    // dut_a sat idle through that capture; its next write slot must be untouched.
    read_word(0, BASE_A + 1, d);
    tests_run++;
    if (d !== mem_a[BASE_A + 1]) begin
      tests_failed++;
      $display("FAIL idle_valid_ignored: got %h expected %h", d, mem_a[BASE_A + 1]);
    end
    for (int k = 0; k < 1024; k++) stim[k] = $urandom;
    run_capture(1, 1024, 1'b1, 1023, $urandom, 1'b0, busy_ok);
    tests_run++;
    if (if_b.overflow !== 1'b0 || if_b.cap_count !== 16'd1024) begin
      tests_failed++;
      $display("FAIL full_status: ovf=%b count=%0d expected 0 1024", if_b.overflow, if_b.cap_count);
    end
    read_word(1, 1019, d);
    tests_run++;
    if (d !== mem_b[1019]) begin
      tests_failed++;
      $display("FAIL full_last_word: got %h expected %h", d, mem_b[1019]);
    end
    for (int k = 0; k < 1025; k++) stim[k] = $urandom;
    run_capture(1, 1025, 1'b0, 0, '0, 1'b0, busy_ok);
    tests_run++;
    if (if_b.overflow !== 1'b1 || if_b.cap_count !== 16'd1025 || if_b.cap_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_status: ovf=%b count=%0d done=%b expected 1 1025 1",
               if_b.overflow, if_b.cap_count, if_b.cap_done);
    end
    for (int a = 1019; a <= 1021; a++) begin
      read_word(1, a, d);
      tests_run++;
      if (d !== mem_b[a]) begin
        tests_failed++;
        $display("FAIL ovf_mem[%0d]: got %h expected %h", a, d, mem_b[a]);
      end
    end
    stim[0] = $urandom;
    stim[1] = $urandom;
    run_capture(1, 2, 1'b0, 0, '0, 1'b0, busy_ok);
    tests_run++;
    if (if_b.overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_cleared: got %b expected 0", if_b.overflow);
    end
  endtask

  task automatic test_reset_mid();
    bit busy_ok;
    logic [WW-1:0] d;
    for (int k = 0; k < 10; k++) stim[k] = $urandom;
    num_words = 16'd10;
    mod_en = 1'b0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cap_valid = 1'b1;
      o_r = stim[k];
      step();
      mem_a[BASE_A + k] = ref_store(stim[k], '0);
    end
    cap_valid = 1'b0;
    rst = 1'b0;
    step();
    tests_run++;
    if (if_a.cap_busy !== 1'b0 || if_a.cap_count !== 16'd0 || if_a.cap_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_status: busy=%b count=%0d done=%b expected 0 0 0",
               if_a.cap_busy, if_a.cap_count, if_a.cap_done);
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      read_word(0, BASE_A + k, d);
      tests_run++;
      if (d !== mem_a[BASE_A + k]) begin
        tests_failed++;
        $display("FAIL midrst_kept[%0d]: got %h expected %h", BASE_A + k, d, mem_a[BASE_A + k]);
      end
    end
    stim[0] = $urandom;
    stim[1] = $urandom;
    run_capture(0, 2, 1'b0, 0, '0, 1'b1, busy_ok);
    tests_run++;
    if (if_a.cap_count !== 16'd2 || if_a.cap_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_restart: count=%0d done=%b expected 2 1", if_a.cap_count, if_a.cap_done);
    end
    for (int k = 0; k < 3; k++) begin
      read_word(0, BASE_A + k, d);
      tests_run++;
      if (d !== mem_a[BASE_A + k]) begin
        tests_failed++;
        $display("FAIL midrst_mem[%0d]: got %h expected %h", BASE_A + k, d, mem_a[BASE_A + k]);
      end
    end
  endtask

  task automatic test_bitswap();
    bit busy_ok;
    logic [WW-1:0] d;
    stim[0] = 32'h0000_0001;
    run_capture(0, 1, 1'b0, 0, '0, 1'b0, busy_ok);
    read_word(0, BASE_A, d);
    tests_run++;
`ifdef RBF_BITSWAP_EN
    if (d !== 32'h0000_0080) begin
      tests_failed++;
      $display("FAIL bitswap: got %h expected 00000080", d);
    end
`else
    if (d !== 32'h0000_0001) begin
      tests_failed++;
      $display("FAIL bitswap: got %h expected 00000001", d);
    end
`endif
  endtask

  initial begin
    start_a   = 1'b0;
    start_b   = 1'b0;
    cap_valid = 1'b0;
    mod_en    = 1'b0;
    num_words = '0;
    mod_idx   = '0;
    o_r       = '0;
    mod_mask  = '0;
    read_addr = '0;
    test_reset();
    test_basic();
    test_mod_edit();
    test_random();
    test_zero_words();
    test_start_ignored();
    test_read_first();
    test_wrap();
    test_reset_mid();
    test_bitswap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
